// File: rtl/dtree_node_sequencer_pkg.sv
// Shared definitions for the oblique decision-tree node sequencer.
//   state_t    : walk FSM states
//   COEF_*     : 2-bit ternary coefficient encodings (2'b10 is reserved, decoded as zero)
package dtree_node_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LATCH  = 3'd2,
        S_ACC    = 3'd3,
        S_DECIDE = 3'd4
    } state_t;

    localparam logic [1:0] COEF_ZERO = 2'b00;
    localparam logic [1:0] COEF_POS  = 2'b01;
    localparam logic [1:0] COEF_NEG  = 2'b11;

endpackage

// File: rtl/dtree_node_sequencer_term_select.sv
// Combinational term generator for one accumulator step.
// Selects feature k, applies the ternary coefficient for k and saturates the
// negation so that -(most negative) becomes the most positive value.
//   i_features : N_FEAT packed signed features, feature k at [k*IN_WIDTH +: IN_WIDTH]
//   i_coef     : N_FEAT packed 2-bit coefficients, coef k at [2k +: 2]
//   i_k        : feature index
//   o_term     : signed term for the accumulator
module dtree_node_sequencer_term_select
    import dtree_node_sequencer_pkg::*;
#(
    parameter int IN_WIDTH = 14,
    parameter int N_FEAT   = 4,
    parameter int KW       = 2
) (
    input  logic [N_FEAT*IN_WIDTH-1:0] i_features,
    input  logic [2*N_FEAT-1:0]        i_coef,
    input  logic [KW-1:0]              i_k,
    output logic [IN_WIDTH-1:0]        o_term
);

    localparam logic [IN_WIDTH-1:0] MOST_NEG = {1'b1, {(IN_WIDTH-1){1'b0}}};
    localparam logic [IN_WIDTH-1:0] MOST_POS = {1'b0, {(IN_WIDTH-1){1'b1}}};

    logic [IN_WIDTH-1:0] w_x;
    logic [1:0]          w_c;

    // An out-of-range index selects nothing and therefore yields a zero term.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        w_x = '0;
        w_c = COEF_ZERO;
        for (int i = 0; i < N_FEAT; i++) begin
            if (i_k == KW'(i)) begin
                w_x = i_features[i*IN_WIDTH +: IN_WIDTH];
                w_c = i_coef[2*i +: 2];
            end
        end
    end

    always_comb begin
        case (w_c)
            COEF_POS: o_term = w_x;
            COEF_NEG: o_term = (w_x == MOST_NEG) ? MOST_POS : -w_x;
            default:  o_term = '0;
        endcase
    end

endmodule

// File: rtl/dtree_node_sequencer.sv
// Walks an oblique decision tree for one feature vector. For each internal node
// it fetches the node word, loads -threshold into the external accumulator,
// adds the ternary-weighted features and branches on the sign of the result.
// A leaf produces the class id; too many internal visits produce an error result.
//   i_clk, i_reset      : clock, synchronous active-high reset
//   i_start, i_features : feature vector handshake (accepted only when idle)
//   o_busy              : walk in progress
//   o_start_dropped     : 1-cycle pulse, start seen while busy
//   o_node_rd/addr, i_node_data : node ROM port, data valid the cycle after read
//   o_acc_load/add/init/a, i_acc_y, i_acc_overflow : accumulator control/status
//   o_class_valid/id/ovf/err : result (id/ovf/err held until next result)
module dtree_node_sequencer
    import dtree_node_sequencer_pkg::*;
#(
    parameter int IN_WIDTH  = 14,
    parameter int N_FEAT    = 4,
    parameter int ADDR_W    = 6,
    parameter int CLASS_W   = 4,
    parameter int MAX_DEPTH = 16,
    localparam int ACC_W    = IN_WIDTH + 1,
    localparam int NODE_W   = 1 + CLASS_W + 2*ADDR_W + ACC_W + 2*N_FEAT
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_start,
    input  logic [N_FEAT*IN_WIDTH-1:0] i_features,
    output logic                       o_busy,
    output logic                       o_start_dropped,
    output logic                       o_node_rd,
    output logic [ADDR_W-1:0]          o_node_addr,
    input  logic [NODE_W-1:0]          i_node_data,
    output logic                       o_acc_load,
    output logic                       o_acc_add,
    output logic [ACC_W-1:0]           o_acc_init,
    output logic [IN_WIDTH-1:0]        o_acc_a,
    input  logic [ACC_W-1:0]           i_acc_y,
    input  logic                       i_acc_overflow,
    output logic                       o_class_valid,
    output logic [CLASS_W-1:0]         o_class_id,
    output logic                       o_class_ovf,
    output logic                       o_class_err
);

    // Node word layout, LSB upwards: coef, threshold, right, left, class, is_leaf.
    localparam int THR_LSB   = 2*N_FEAT;
    localparam int RIGHT_LSB = THR_LSB + ACC_W;
    localparam int LEFT_LSB  = RIGHT_LSB + ADDR_W;
    localparam int CLASS_LSB = LEFT_LSB + ADDR_W;
    localparam int LEAF_BIT  = CLASS_LSB + CLASS_W;
    localparam int KW        = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam int DW        = $clog2(MAX_DEPTH + 1);

    localparam logic [ACC_W-1:0] THR_MOST_NEG = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [ACC_W-1:0] THR_MOST_POS = {1'b0, {(ACC_W-1){1'b1}}};

    state_t                      r_state;
    logic [N_FEAT*IN_WIDTH-1:0]  r_features;
    logic [NODE_W-1:0]           r_node;
    logic [KW-1:0]               r_k;
    logic [DW-1:0]               r_depth;
    logic                        r_ovf;

    logic                        r_start_dropped, r_node_rd, r_acc_load, r_acc_add;
    logic [ADDR_W-1:0]           r_node_addr;
    logic [ACC_W-1:0]            r_acc_init;
    logic [IN_WIDTH-1:0]         r_acc_a;
    logic                        r_class_valid, r_class_ovf, r_class_err;
    logic [CLASS_W-1:0]          r_class_id;

    logic [2*N_FEAT-1:0]         w_coef;
    logic [KW-1:0]               w_k_next;
    logic [IN_WIDTH-1:0]         w_term;
    logic [ACC_W-1:0]            w_thr;
    logic [ACC_W-1:0]            w_neg_thr;

    // Accumulator controls are registered, so the term for the next ACC cycle
    // is computed one cycle early: from the ROM word while it is being latched,
    // otherwise from the stored node word.
    assign w_coef    = (r_state == S_LATCH) ? i_node_data[THR_LSB-1:0] : r_node[THR_LSB-1:0];
    assign w_k_next  = (r_state == S_LATCH) ? '0 : r_k + 1'b1;
    assign w_thr     = i_node_data[THR_LSB +: ACC_W];
    assign w_neg_thr = (w_thr == THR_MOST_NEG) ? THR_MOST_POS : -w_thr;

    dtree_node_sequencer_term_select #(
        .IN_WIDTH (IN_WIDTH),
        .N_FEAT   (N_FEAT),
        .KW       (KW)
    ) u_term_select (
        .i_features (r_features),
        .i_coef     (w_coef),
        .i_k        (w_k_next),
        .o_term     (w_term)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state         <= S_IDLE;
            r_features      <= '0;
            r_node          <= '0;
            r_k             <= '0;
            r_depth         <= '0;
            r_ovf           <= 1'b0;
            r_start_dropped <= 1'b0;
            r_node_rd       <= 1'b0;
            r_node_addr     <= '0;
            r_acc_load      <= 1'b0;
            r_acc_add       <= 1'b0;
            r_acc_init      <= '0;
            r_acc_a         <= '0;
            r_class_valid   <= 1'b0;
            r_class_id      <= '0;
            r_class_ovf     <= 1'b0;
            r_class_err     <= 1'b0;
        end else begin
            // Strobes and accumulator controls default low each cycle.
            r_start_dropped <= i_start && (r_state != S_IDLE);
            r_node_rd       <= 1'b0;
            r_acc_load      <= 1'b0;
            r_acc_add       <= 1'b0;
            r_acc_init      <= '0;
            r_acc_a         <= '0;
            r_class_valid   <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_features  <= i_features;
                        r_node_addr <= '0;
                        r_depth     <= '0;
                        r_ovf       <= 1'b0;
                        r_node_rd   <= 1'b1;
                        r_state     <= S_FETCH;
                    end
                end
                S_FETCH: r_state <= S_LATCH;
                S_LATCH: begin
                    r_node <= i_node_data;
                    if (i_node_data[LEAF_BIT]) begin
                        r_class_valid <= 1'b1;
                        r_class_id    <= i_node_data[CLASS_LSB +: CLASS_W];
                        r_class_ovf   <= r_ovf;
                        r_class_err   <= 1'b0;
                        r_state       <= S_IDLE;
                    end else if (r_depth == DW'(MAX_DEPTH)) begin
                        r_class_valid <= 1'b1;
                        r_class_id    <= '1;
                        r_class_ovf   <= r_ovf;
                        r_class_err   <= 1'b1;
                        r_state       <= S_IDLE;
                    end else begin
                        r_k        <= '0;
                        r_acc_load <= 1'b1;
                        r_acc_add  <= 1'b1;
                        r_acc_init <= w_neg_thr;
                        r_acc_a    <= w_term;
                        r_state    <= S_ACC;
                    end
                end
                S_ACC: begin
                    r_ovf <= r_ovf | i_acc_overflow;
                    if (r_k == KW'(N_FEAT - 1)) begin
                        r_state <= S_DECIDE;
                    end else begin
                        r_k       <= w_k_next;
                        r_acc_add <= 1'b1;
                        r_acc_a   <= w_term;
                    end
                end
                S_DECIDE: begin
                    // Negative sum-minus-threshold means sum < threshold: go left.
                    r_node_addr <= i_acc_y[IN_WIDTH] ? r_node[LEFT_LSB +: ADDR_W]
                                                     : r_node[RIGHT_LSB +: ADDR_W];
                    r_depth     <= r_depth + 1'b1;
                    r_node_rd   <= 1'b1;
                    r_state     <= S_FETCH;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy          = (r_state != S_IDLE);
    assign o_start_dropped = r_start_dropped;
    assign o_node_rd       = r_node_rd;
    assign o_node_addr     = r_node_addr;
    assign o_acc_load      = r_acc_load;
    assign o_acc_add       = r_acc_add;
    assign o_acc_init      = r_acc_init;
    assign o_acc_a         = r_acc_a;
    assign o_class_valid   = r_class_valid;
    assign o_class_id      = r_class_id;
    assign o_class_ovf     = r_class_ovf;
    assign o_class_err     = r_class_err;

endmodule

// File: tb/tb_dtree_node_sequencer.sv
module tb_dtree_node_sequencer;

    localparam int IN_WIDTH = 14;
    localparam int N_FEAT   = 4;
    localparam int ADDR_W   = 6;
    localparam int CLASS_W  = 4;
    localparam int MAXD     = 16;
    localparam int ACC_W    = IN_WIDTH + 1;
    localparam int NODE_W   = 1 + CLASS_W + 2*ADDR_W + ACC_W + 2*N_FEAT;
    localparam int FW       = N_FEAT * IN_WIDTH;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [FW-1:0]     features;
    logic              busy, start_dropped, node_rd;
    logic [ADDR_W-1:0] node_addr;
    logic [NODE_W-1:0] node_data;
    logic              acc_load, acc_add;
    logic [ACC_W-1:0]  acc_init;
    logic [IN_WIDTH-1:0] acc_a;
    logic [ACC_W-1:0]  acc_y;
    logic              acc_overflow;
    logic              class_valid, class_ovf, class_err;
    logic [CLASS_W-1:0] class_id;

    int errors = 0;
    int checks = 0;

    logic [NODE_W-1:0] rom [64];

    always #5 clk = ~clk;

    dtree_node_sequencer #(
        .IN_WIDTH(IN_WIDTH), .N_FEAT(N_FEAT), .ADDR_W(ADDR_W),
        .CLASS_W(CLASS_W), .MAX_DEPTH(MAXD)
    ) dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_features(features),
        .o_busy(busy), .o_start_dropped(start_dropped),
        .o_node_rd(node_rd), .o_node_addr(node_addr), .i_node_data(node_data),
        .o_acc_load(acc_load), .o_acc_add(acc_add), .o_acc_init(acc_init),
        .o_acc_a(acc_a), .i_acc_y(acc_y), .i_acc_overflow(acc_overflow),
        .o_class_valid(class_valid), .o_class_id(class_id),
        .o_class_ovf(class_ovf), .o_class_err(class_err)
    );

    // Behavioural 1-cycle ROM.
    always @(posedge clk) if (node_rd) node_data <= rom[node_addr];

    // Behavioural accumulator: y <= (load ? init : y) + a, overflow flagged in the add cycle.
    logic [ACC_W:0]   acc_sum;
    logic [ACC_W-1:0] acc_base;
    assign acc_base     = acc_load ? acc_init : acc_y;
    assign acc_sum      = {acc_base[ACC_W-1], acc_base} + {{2{acc_a[IN_WIDTH-1]}}, acc_a};
    assign acc_overflow = acc_add && (acc_sum[ACC_W] != acc_sum[ACC_W-1]);
    always @(posedge clk) begin
        if (reset) acc_y <= '0;
        else if (acc_add) acc_y <= acc_sum[ACC_W-1:0];
    end

    function automatic logic [NODE_W-1:0] mk_leaf(input int cls);
        logic [NODE_W-1:0] w;
        w = '0;
        w[NODE_W-1] = 1'b1;
        w[NODE_W-2 -: CLASS_W] = CLASS_W'(cls);
        return w;
    endfunction

    function automatic logic [NODE_W-1:0] mk_node(input int left, input int right,
                                                  input int thr, input logic [7:0] coef);
        logic [NODE_W-1:0] w;
        w = '0;
        w[34:29] = ADDR_W'(left);
        w[28:23] = ADDR_W'(right);
        w[22:8]  = ACC_W'(thr);
        w[7:0]   = coef;
        return w;
    endfunction

    function automatic logic [FW-1:0] pack4(input int x0, input int x1, input int x2, input int x3);
        return {IN_WIDTH'(x3), IN_WIDTH'(x2), IN_WIDTH'(x1), IN_WIDTH'(x0)};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 64; i++) rom[i] = mk_leaf(0);
    endtask

    // Reference walk with plain integer arithmetic on the tree semantics.
    function automatic void model(input logic [FW-1:0] f, output logic [3:0] cls,
                                  output logic ovf, output logic err, output int lat);
        int addr, depth, thr, acc, x, t, full;
        logic [NODE_W-1:0] w;
        logic [1:0] c;
        addr = 0; depth = 0; ovf = 1'b0; err = 1'b0; cls = '0;
        for (int it = 0; it < 100; it++) begin
            w = rom[addr];
            if (w[39]) begin
                cls = w[38:35];
                break;
            end
            if (depth == MAXD) begin
                err = 1'b1; cls = 4'hF;
                break;
            end
            thr = int'($signed(w[22:8]));
            acc = (thr == -16384) ? 16383 : -thr;
            for (int k = 0; k < N_FEAT; k++) begin
                c = w[2*k +: 2];
                x = int'($signed(f[k*IN_WIDTH +: IN_WIDTH]));
                if (c == 2'b01)      t = x;
                else if (c == 2'b11) t = (x == -8192) ? 8191 : -x;
                else                 t = 0;
                full = acc + t;
                if (full > 16383 || full < -16384) ovf = 1'b1;
                if (full > 16383) full -= 32768;
                if (full < -16384) full += 32768;
                acc = full;
            end
            addr = (acc < 0) ? int'(w[34:29]) : int'(w[28:23]);
            depth++;
        end
        lat = 3 + depth * (N_FEAT + 3);
    endfunction

    // Present a start in the current cycle and wait for the result (bounded).
    task automatic run_walk(input logic [FW-1:0] f, output int lat, output logic [3:0] cls,
                            output logic ovf, output logic err);
        features = f;
        start = 1'b1;
        lat = -1; cls = '0; ovf = 1'b0; err = 1'b0;
        for (int c = 1; c <= 1000; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (class_valid) begin
                lat = c; cls = class_id; ovf = class_ovf; err = class_err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; features = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if ({busy, start_dropped, node_rd, node_addr, acc_load, acc_add, acc_init, acc_a,
             class_valid, class_id, class_ovf, class_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b rd=%b addr=%0d load=%b add=%b valid=%b id=%0d required all zero",
                     busy, node_rd, node_addr, acc_load, acc_add, class_valid, class_id);
        end
    endtask

    task automatic test_leaf_root();
        int lat; logic [3:0] cls; logic ovf, err;
        clear_rom();
        rom[0] = mk_leaf(5);
        run_walk(pack4(1, 2, 3, 4), lat, cls, ovf, err);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL leaf_latency: got %0d need 3", lat); end
        checks++;
        if ({cls, ovf, err} !== {4'd5, 2'b00}) begin
            errors++; $display("FAIL leaf_result: id=%0d ovf=%b err=%b need id=5 ovf=0 err=0", cls, ovf, err);
        end
    endtask

    task automatic test_boundary();
        int lat; logic [3:0] cls; logic ovf, err;
        clear_rom();
        rom[0] = mk_node(1, 2, 10, 8'hC5);
        rom[1] = mk_leaf(1);
        rom[2] = mk_leaf(2);
        run_walk(pack4(8, 7, 3, 4), lat, cls, ovf, err);
        checks++;
        if (lat !== 10) begin errors++; $display("FAIL sum_plus1_latency: got %0d need 10", lat); end
        checks++;
        if ({cls, ovf, err} !== {4'd2, 2'b00}) begin
            errors++; $display("FAIL sum_plus1_class: id=%0d ovf=%b err=%b need id=2", cls, ovf, err);
        end
        run_walk(pack4(8, 7, 3, 6), lat, cls, ovf, err);
        checks++;
        if (lat !== 10) begin errors++; $display("FAIL sum_minus1_latency: got %0d need 10", lat); end
        checks++;
        if ({cls, ovf, err} !== {4'd1, 2'b00}) begin
            errors++; $display("FAIL sum_minus1_class: id=%0d ovf=%b err=%b need id=1", cls, ovf, err);
        end
    endtask

    task automatic test_saturation();
        int lat; logic [3:0] cls; logic ovf, err;
        logic a_seen;
        clear_rom();
        rom[0] = mk_node(1, 2, 0, 8'h57);
        rom[1] = mk_leaf(3);
        rom[2] = mk_leaf(4);
        features = pack4(-8192, 8191, 8191, 8191);
        start = 1'b1;
        a_seen = 1'b0;
        lat = -1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (c == 3) begin
                checks++;
                if (acc_load !== 1'b1 || acc_a !== 14'd8191) begin
                    errors++; $display("FAIL sat_term: load=%b acc_a=%0d need load=1 acc_a=8191", acc_load, acc_a);
                end
            end
            if (class_valid) begin lat = c; cls = class_id; ovf = class_ovf; err = class_err; break; end
        end
        // 4*8191 wraps negative in the 15-bit accumulator -> left.
        checks++;
        if ({lat == 10, cls, ovf, err} !== {1'b1, 4'd3, 1'b1, 1'b0}) begin
            errors++; $display("FAIL sat_overflow: lat=%0d id=%0d ovf=%b err=%b need lat=10 id=3 ovf=1 err=0",
                               lat, cls, ovf, err);
        end
        // -(-16384) must saturate to +16383 (non-negative -> right).
        rom[0] = mk_node(1, 2, -16384, 8'h00);
        run_walk(pack4(0, 0, 0, 0), lat, cls, ovf, err);
        checks++;
        if ({lat == 10, cls, ovf} !== {1'b1, 4'd4, 1'b0}) begin
            errors++; $display("FAIL sat_threshold: lat=%0d id=%0d ovf=%b need lat=10 id=4 ovf=0", lat, cls, ovf);
        end
    endtask

    task automatic test_depth_abort();
        int lat; logic [3:0] cls; logic ovf, err;
        clear_rom();
        rom[0] = mk_node(0, 0, 0, 8'h00);
        run_walk(pack4(5, 5, 5, 5), lat, cls, ovf, err);
        checks++;
        if (lat !== 16 * 7 + 3) begin errors++; $display("FAIL depth_latency: got %0d need 115", lat); end
        checks++;
        if ({cls, err} !== {4'hF, 1'b1}) begin
            errors++; $display("FAIL depth_result: id=%0h err=%b need id=f err=1", cls, err);
        end
    endtask

    task automatic test_start_dropped();
        int lat;
        logic [3:0] cls;
        clear_rom();
        rom[0] = mk_node(1, 2, 10, 8'hC5);
        rom[1] = mk_leaf(1);
        rom[2] = mk_leaf(2);
        features = pack4(8, 7, 3, 4);
        start = 1'b1;
        lat = -1; cls = '0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (c == 4) begin
                start = 1'b1;
                features = pack4(0, 0, 0, 100);
            end
            if (c == 5) begin
                checks++;
                if ({start_dropped, busy} !== 2'b11) begin
                    errors++; $display("FAIL dropped_pulse: dropped=%b busy=%b need 1 1", start_dropped, busy);
                end
            end
            if (c == 6) begin
                checks++;
                if (start_dropped !== 1'b0) begin errors++; $display("FAIL dropped_width: got %b need 0", start_dropped); end
            end
            if (class_valid) begin lat = c; cls = class_id; break; end
        end
        checks++;
        if ({lat == 10, cls} !== {1'b1, 4'd2}) begin
            errors++; $display("FAIL dropped_result: lat=%0d id=%0d need lat=10 id=2", lat, cls);
        end
    endtask

    task automatic test_reset_mid_walk();
        int lat; logic [3:0] cls; logic ovf, err;
        logic seen;
        features = pack4(8, 7, 3, 6);
        start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;                      // cycle 3: first ACC cycle
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if ({busy, acc_add, acc_load, node_rd, class_valid} !== 5'b0) begin
            errors++; $display("FAIL reset_mid_walk: busy=%b add=%b load=%b rd=%b valid=%b need all 0",
                               busy, acc_add, acc_load, node_rd, class_valid);
        end
        seen = 1'b0;
        repeat (30) begin @(posedge clk); #1; if (class_valid) seen = 1'b1; end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL reset_no_result: class_valid=%b need 0", seen); end
        run_walk(pack4(8, 7, 3, 6), lat, cls, ovf, err);
        checks++;
        if ({lat == 10, cls} !== {1'b1, 4'd1}) begin
            errors++; $display("FAIL reset_recover: lat=%0d id=%0d need lat=10 id=1", lat, cls);
        end
    endtask

    // Random trees and features, walks issued back to back in the result cycle.
    task automatic test_random();
        int lat, exp_lat; logic [3:0] cls, exp_cls; logic ovf, err, exp_ovf, exp_err;
        logic [FW-1:0] f;
        for (int t = 0; t < 6; t++) begin
            clear_rom();
            for (int i = 0; i < 15; i++) begin
                if (i >= 7 || (i > 0 && $urandom_range(0, 3) == 0))
                    rom[i] = mk_leaf(int'($urandom_range(0, 15)));
                else
                    rom[i] = mk_node(2*i + 1, 2*i + 2, int'($urandom_range(0, 32767)) - 16384,
                                     8'($urandom));
            end
            for (int n = 0; n < 8; n++) begin
                f = {$urandom, $urandom};
                if ($urandom_range(0, 1) == 0) f = pack4(int'($urandom_range(0, 2000)) - 1000,
                                                         int'($urandom_range(0, 2000)) - 1000,
                                                         int'($urandom_range(0, 2000)) - 1000,
                                                         int'($urandom_range(0, 2000)) - 1000);
                model(f, exp_cls, exp_ovf, exp_err, exp_lat);
                run_walk(f, lat, cls, ovf, err);
                checks++;
                if (lat !== exp_lat) begin
                    errors++; $display("FAIL rand_latency[%0d.%0d]: got %0d need %0d", t, n, lat, exp_lat);
                end
                checks++;
                if ({cls, ovf, err} !== {exp_cls, exp_ovf, exp_err}) begin
                    errors++; $display("FAIL rand_result[%0d.%0d]: id=%0d ovf=%b err=%b need id=%0d ovf=%b err=%b",
                                       t, n, cls, ovf, err, exp_cls, exp_ovf, exp_err);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_leaf_root();
        test_boundary();
        test_saturation();
        test_depth_abort();
        test_start_dropped();
        test_reset_mid_walk();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
